// File: rtl/seq_gen_pkg.sv
// Shared types and defaults for the serial frame generator.
// Holds the FSM state encoding, the default sync marker and a helper
// that sizes the bit counter.
package seq_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SYNC,
        ST_DATA,
        ST_PARITY
    } state_e;

    localparam int                    DEF_SYNC_W   = 4;
    localparam logic [DEF_SYNC_W-1:0] DEF_SYNC_PAT = 4'b1011;

    // Counter width: enough bits to hold max(a,b)-1, never less than one bit.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage : seq_gen_pkg

// File: rtl/seq_frame_gen_if.sv
// Payload handshake bundle between a word source and the frame generator.
// The master offers in_valid/in_data; the slave answers with in_ready.
interface seq_frame_gen_if #(
    parameter int DATA_W = 8
) ();

    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready
    );

endinterface : seq_frame_gen_if

// File: rtl/seq_gen_piso.sv
// Parallel-in serial-out shift register. Load has priority over shift;
// the MSB is always presented on msb_o and each shift moves the next bit up.
module seq_gen_piso #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             msb_o
);

    logic [WIDTH-1:0] sh_q;

    // Capture a new word on load, otherwise shift left towards the MSB.
    // NOTE: clocked state is always written with <= so every register samples
    // the pre-edge values of its inputs, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q <= '0;
        end else if (load_i) begin
            sh_q <= data_i;
        end else if (shift_i) begin
            sh_q <= sh_q << 1;
        end
    end

    assign msb_o = sh_q[WIDTH-1];

endmodule : seq_gen_piso

// File: rtl/seq_frame_gen.sv
// Serial frame transmitter: sync marker, then payload MSB-first, then an
// optional even-parity bit, on a registered single-bit line idling at 0.
// Optional feature: define SEQ_FRAME_GEN_PARITY_EN to append the parity bit.
module seq_frame_gen
    import seq_gen_pkg::*;
#(
    parameter int                DATA_W   = 8,
    parameter int                SYNC_W   = DEF_SYNC_W,
    parameter logic [SYNC_W-1:0] SYNC_PAT = DEF_SYNC_PAT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    seq_frame_gen_if.slave        in_if,
    output logic                  x_out,
    output logic                  busy,
    output logic                  done
);

    localparam int              CW        = cnt_width(SYNC_W, DATA_W);
    localparam logic [CW-1:0]   SYNC_LAST = CW'(SYNC_W - 1);
    localparam logic [CW-1:0]   DATA_LAST = CW'(DATA_W - 1);
    localparam logic [CW-1:0]   CNT_ONE   = CW'(1);

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              x_out_q, x_out_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              hs;
    logic              load;
    logic              shift;
    logic              payload_msb;
    logic [SYNC_W-1:0] sync_sh;
`ifdef SEQ_FRAME_GEN_PARITY_EN
    logic              parity_q;
`endif

    assign in_if.in_ready = (state_q == ST_IDLE);
    assign hs             = in_if.in_valid && (state_q == ST_IDLE);

    seq_gen_piso #(
        .WIDTH (DATA_W)
    ) u_payload (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (load),
        .shift_i (shift),
        .data_i  (in_if.in_data),
        .msb_o   (payload_msb)
    );

    // Next state and counter, then the line value for the bit that the next
    // state will carry, so x_out/done/busy can be registered without lag.
    // NOTE: every variable driven here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        shift   = 1'b0;
        x_out_d = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (hs) begin
                    state_d = ST_SYNC;
                    cnt_d   = SYNC_LAST;
                    load    = 1'b1;
                end
            end
            ST_SYNC: begin
                if (cnt_q == '0) begin
                    state_d = ST_DATA;
                    cnt_d   = DATA_LAST;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_DATA: begin
                if (cnt_q == '0) begin
`ifdef SEQ_FRAME_GEN_PARITY_EN
                    state_d = ST_PARITY;
`else
                    state_d = ST_IDLE;
`endif
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
`ifdef SEQ_FRAME_GEN_PARITY_EN
            ST_PARITY: begin
                state_d = ST_IDLE;
            end
`endif
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        sync_sh = SYNC_PAT >> cnt_d;

        case (state_d)
            ST_SYNC: begin
                x_out_d = sync_sh[0];
            end
            ST_DATA: begin
                // The shift register's MSB is the next payload bit; consume it.
                x_out_d = payload_msb;
                shift   = 1'b1;
`ifndef SEQ_FRAME_GEN_PARITY_EN
                done_d  = (cnt_d == '0);
`endif
            end
`ifdef SEQ_FRAME_GEN_PARITY_EN
            ST_PARITY: begin
                x_out_d = parity_q;
                done_d  = 1'b1;
            end
`endif
            default: begin
                x_out_d = 1'b0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State, counter and registered line outputs; reset aborts any frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            x_out_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_out_q <= x_out_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

`ifdef SEQ_FRAME_GEN_PARITY_EN
    // Even parity of the accepted payload, latched at the handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_q <= 1'b0;
        end else if (hs) begin
            parity_q <= ^in_if.in_data;
        end
    end
`endif

    assign x_out = x_out_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule : seq_frame_gen

// File: doc/seq_frame_gen.md
Name: seq_frame_gen

Overview:
- Serial frame transmitter that drives single-bit streams into the team's overlapping 1011 sequence detectors.
- Accepts a parallel payload word over a valid/ready handshake.
- Emits a frame MSB-first on a registered serial output: sync marker first, then the payload, then an optional parity bit.
- Line idles at 0 between frames. Used as the stimulus and transmit end for detector-based framing links.

Parameters:
- DATA_W, 8, payload width in bits (≥1).
- SYNC_W, 4, sync marker width in bits (≥1).
- SYNC_PAT, 4'b1011, sync marker value; SYNC_W bits, sent MSB first.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  payload offered.
- in_data  in  DATA_W  payload word; sampled on handshake.
- in_ready  out  1  block can accept a payload; combinational, equal to (state==IDLE).
- x_out  out  1  serial line, registered.
- busy  out  1  frame in progress, registered; equals (state!=IDLE).
- done  out  1  one-cycle pulse, registered; high in the same cycle x_out carries the final frame bit.

Behaviour:
- Reset is async, active-low. While rst_n=0:
  - state=IDLE
  - x_out=0, busy=0, done=0
  - shift register and bit counter cleared
- Handshake: transfer occurs on the rising edge where in_valid && in_ready. in_data is captured into the payload register on that edge. in_valid without in_ready is ignored and never queued; the source holds its data.
- FSM states: IDLE, SYNC, DATA, PARITY (parity build only).
  - IDLE: x_out=0. On handshake go to SYNC, counter=SYNC_W-1.
  - SYNC: x_out=SYNC_PAT[counter]. When counter reaches 0, go to DATA with counter=DATA_W-1.
  - DATA: x_out=payload[counter], MSB first. When counter reaches 0, go to PARITY if enabled, else IDLE.
  - PARITY: x_out = even parity (XOR of the payload bits). Then go to IDLE.
- Latency and timing:
  - Handshake at edge T0 puts the first sync bit on x_out in cycle T0+1.
  - Frame length L = SYNC_W+DATA_W (+1 with parity). Last bit is in cycle T0+L, and done=1 only in that cycle.
  - in_ready returns high in cycle T0+L+1. x_out is 0 in that cycle.
  - Back-to-back frames with in_valid held high are therefore separated by exactly one idle 0 bit.
  - Maximum throughput is one frame per L+1 cycles.
- in_data changes while busy have no effect.
- Payload containing SYNC_PAT: transmitted unmodified, no stuffing. Avoiding false sync is the receiver's responsibility.
- Reset asserted mid-frame: frame aborted immediately and asynchronously, x_out=0. After release the block is in IDLE and the aborted frame is never resumed.
- Counter width is $clog2(max(SYNC_W,DATA_W)), minimum 1 bit. It must never wrap below 0; the terminal check is counter==0.

Optional Feature:
- Macro SEQ_FRAME_GEN_PARITY_EN.
- Defined: the PARITY state exists, L = SYNC_W+DATA_W+1, and the parity bit is even parity over the payload only.
- Undefined: no PARITY state or logic, L = SYNC_W+DATA_W, and done coincides with the payload LSB.

Decomposition:
- Package seq_gen_pkg holds:
  - state enum (IDLE, SYNC, DATA, PARITY)
  - default SYNC_PAT constant 4'b1011
  - SYNC_W constant
- One sub-module, seq_gen_piso, parameterised by width:
  - parallel-in serial-out shift register with load, shift, and MSB output
  - used for the payload
- The FSM and counter stay in the top level.

Test Plan:
- Reset check: assert rst_n=0 mid-run, then release → x_out=0, busy=0, done=0, in_ready=1, and no spurious bits for 10 idle cycles.
- Single frame, no parity: in_data=8'hA5 with handshake at T0 → cycles T0+1..T0+12 carry 1011_10100101, done only at T0+12, in_ready=1 at T0+13.
- Parity build: in_data=8'h07 → frame 1011_00000111 followed by parity bit 1, giving L=13. in_data=8'hA5 → parity bit 0.
- Back-to-back: in_valid held with 8'hFF then 8'h00 → exactly one 0 between frames. A 1011 detector connected downstream fires once per sync marker plus on any 1011 patterns inside the payload.
- Ignored input: toggle in_data and in_valid during busy → transmitted frame is unchanged and no second frame starts until in_ready is high.
- Abort: assert rst_n low at T0+6 of an 8'hA5 frame → x_out=0 immediately. After release, a new handshake with 8'h3C sends a clean, complete frame.
